// File: rtl/axi_mst_bridge.sv
// axi_mst_bridge: simple request/response bus to AXI4 master, one transaction in flight.
// Read beats and write data each pass through a one-entry register backed by a
// one-entry skid, so registered ready outputs never overwrite held data.

package axi_mst_pkg;
    localparam int CFG_SYSBUS_ADDR_BITS  = 32;
    localparam int CFG_SYSBUS_DATA_BITS  = 64;
    localparam int CFG_SYSBUS_DATA_BYTES = CFG_SYSBUS_DATA_BITS / 8;
    localparam int CFG_SYSBUS_ID_BITS    = 4;
    localparam int CFG_SYSBUS_USER_BITS  = 1;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef struct packed {
        logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
        logic [7:0]                      len;
        logic [2:0]                      size;
        logic [1:0]                      burst;
        logic                            lock;
        logic [3:0]                      cache;
        logic [2:0]                      prot;
        logic [3:0]                      qos;
        logic [3:0]                      region;
    } axi4_meta_type;

    typedef struct packed {
        logic                             aw_valid;
        axi4_meta_type                    aw_bits;
        logic [CFG_SYSBUS_ID_BITS-1:0]    aw_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  aw_user;
        logic                             w_valid;
        logic [CFG_SYSBUS_DATA_BITS-1:0]  w_data;
        logic                             w_last;
        logic [CFG_SYSBUS_DATA_BYTES-1:0] w_strb;
        logic                             b_ready;
        logic                             ar_valid;
        axi4_meta_type                    ar_bits;
        logic [CFG_SYSBUS_ID_BITS-1:0]    ar_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  ar_user;
        logic                             r_ready;
    } axi4_master_out_type;

    typedef struct packed {
        logic                            aw_ready;
        logic                            w_ready;
        logic                            b_valid;
        logic [1:0]                      b_resp;
        logic                            ar_ready;
        logic                            r_valid;
        logic [1:0]                      r_resp;
        logic [CFG_SYSBUS_DATA_BITS-1:0] r_data;
        logic                            r_last;
    } axi4_master_in_type;
endpackage

module axi_mst_bridge
    import axi_mst_pkg::*;
#(
    parameter logic [CFG_SYSBUS_ID_BITS-1:0]   req_id   = '0,
    parameter logic [CFG_SYSBUS_USER_BITS-1:0] req_user = '0
) (
    input  logic                             i_clk,
    input  logic                             i_nrst,
    input  axi4_master_in_type               i_xmsti,
    output axi4_master_out_type              o_xmsto,
    input  logic                             i_req_valid,
    output logic                             o_req_ready,
    input  logic                             i_req_write,
    input  logic [CFG_SYSBUS_ADDR_BITS-1:0]  i_req_addr,
    input  logic [2:0]                       i_req_size,
    input  logic [7:0]                       i_req_len,
    input  logic                             i_wdata_valid,
    output logic                             o_wdata_ready,
    input  logic [CFG_SYSBUS_DATA_BITS-1:0]  i_wdata,
    input  logic [CFG_SYSBUS_DATA_BYTES-1:0] i_wstrb,
    output logic                             o_resp_valid,
    input  logic                             i_resp_ready,
    output logic                             o_resp_write,
    output logic [CFG_SYSBUS_DATA_BITS-1:0]  o_resp_rdata,
    output logic                             o_resp_err,
    output logic                             o_resp_last
);
    localparam logic [2:0] ST_IDLE = 3'd0, ST_AR = 3'd1, ST_R = 3'd2, ST_AW = 3'd3,
                           ST_W = 3'd4, ST_B = 3'd5, ST_RESP = 3'd6;

    logic [2:0]                       state;
    logic                             req_ready, wdata_ready;
    logic                             ar_valid, aw_valid, r_ready, b_ready;
    logic [CFG_SYSBUS_ADDR_BITS-1:0]  a_addr;
    logic [7:0]                       a_len, cnt;
    logic [2:0]                       a_size;
    logic                             w_valid, w_last, wsk_valid, wsk_last, w_done;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  w_data, wsk_data;
    logic [CFG_SYSBUS_DATA_BYTES-1:0] w_strb, wsk_strb;
    logic                             resp_valid, resp_write, resp_err, resp_last;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  resp_rdata, rsk_data;
    logic                             rsk_valid, rsk_err, rsk_last;
    logic                             r_push, b_fire, r_pop, r_free, rv_n, rsk_n;
    logic                             w_push, w_pop, w_free, wv_n, wsk_n, w_load_last;
    logic                             unused_ok;

    assign unused_ok = ^{i_xmsti.b_resp[0], i_xmsti.r_resp[0]};

    // Handshake decode and next occupancy of the response and W register/skid pairs.
    always_comb begin
        r_push = (state == ST_R) && i_xmsti.r_valid && r_ready;
        b_fire = (state == ST_B) && i_xmsti.b_valid && b_ready;
        r_pop  = resp_valid && i_resp_ready;
        r_free = !resp_valid || r_pop;
        rv_n   = resp_valid;
        rsk_n  = rsk_valid;
        if (r_free) begin
            rsk_n = 1'b0;
            rv_n  = rsk_valid || r_push || b_fire;
        end else if (r_push) begin
            rsk_n = 1'b1;
        end
        w_push = i_wdata_valid && wdata_ready;
        w_pop  = w_valid && i_xmsti.w_ready;
        w_free = !w_valid || w_pop;
        wv_n   = w_valid;
        wsk_n  = wsk_valid;
        if (w_free) begin
            wsk_n = 1'b0;
            wv_n  = wsk_valid || w_push;
        end else if (w_push) begin
            wsk_n = 1'b1;
        end
        w_load_last = w_push && (cnt == 8'd0);
    end

    // Response register: skid drains first, then a new R beat or the B completion loads.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            resp_valid <= 1'b0; resp_write <= 1'b0; resp_err <= 1'b0; resp_last <= 1'b0;
            resp_rdata <= '0;
            rsk_valid  <= 1'b0; rsk_err <= 1'b0; rsk_last <= 1'b0; rsk_data <= '0;
        end else begin
            resp_valid <= rv_n;
            rsk_valid  <= rsk_n;
            if (r_free) begin
                if (rsk_valid) begin
                    resp_rdata <= rsk_data; resp_err <= rsk_err;
                    resp_last  <= rsk_last; resp_write <= 1'b0;
                end else if (r_push) begin
                    resp_rdata <= i_xmsti.r_data; resp_err <= i_xmsti.r_resp[1];
                    resp_last  <= i_xmsti.r_last; resp_write <= 1'b0;
                end else if (b_fire) begin
                    resp_rdata <= '0; resp_err <= i_xmsti.b_resp[1];
                    resp_last  <= 1'b1; resp_write <= 1'b1;
                end
            end else if (r_push) begin
                rsk_data <= i_xmsti.r_data; rsk_err <= i_xmsti.r_resp[1];
                rsk_last <= i_xmsti.r_last;
            end
        end
    end

    // Transaction FSM plus AR/AW/W/B channel registers.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state <= ST_IDLE; req_ready <= 1'b0; wdata_ready <= 1'b0;
            ar_valid <= 1'b0; aw_valid <= 1'b0; r_ready <= 1'b0; b_ready <= 1'b0;
            a_addr <= '0; a_len <= '0; a_size <= '0; cnt <= '0; w_done <= 1'b0;
            w_valid <= 1'b0; w_last <= 1'b0; w_data <= '0; w_strb <= '0;
            wsk_valid <= 1'b0; wsk_last <= 1'b0; wsk_data <= '0; wsk_strb <= '0;
        end else begin
            w_valid   <= wv_n;
            wsk_valid <= wsk_n;
            if (w_free) begin
                if (wsk_valid) begin
                    w_data <= wsk_data; w_strb <= wsk_strb; w_last <= wsk_last;
                end else if (w_push) begin
                    w_data <= i_wdata; w_strb <= i_wstrb; w_last <= w_load_last;
                end
            end else if (w_push) begin
                wsk_data <= i_wdata; wsk_strb <= i_wstrb; wsk_last <= w_load_last;
            end
            if (w_push) cnt <= cnt - 8'd1;
            if (w_load_last) w_done <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (i_req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        a_addr <= i_req_addr; a_len <= i_req_len; a_size <= i_req_size;
                        if (i_req_write) begin aw_valid <= 1'b1; state <= ST_AW; end
                        else             begin ar_valid <= 1'b1; state <= ST_AR; end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_AR: if (i_xmsti.ar_ready) begin
                    ar_valid <= 1'b0;
                    r_ready  <= !resp_valid || i_resp_ready;
                    state    <= ST_R;
                end
                ST_R: begin
                    if (r_push && i_xmsti.r_last) begin
                        r_ready <= 1'b0; state <= ST_RESP;
                    end else begin
                        r_ready <= (!rv_n || i_resp_ready) && !rsk_n;
                    end
                end
                ST_AW: if (i_xmsti.aw_ready) begin
                    aw_valid <= 1'b0; cnt <= a_len; w_done <= 1'b0;
                    wdata_ready <= 1'b1; state <= ST_W;
                end
                ST_W: begin
                    if (w_pop && w_last) begin
                        wdata_ready <= 1'b0; b_ready <= 1'b1; state <= ST_B;
                    end else begin
                        wdata_ready <= (!wv_n || i_xmsti.w_ready) && !wsk_n && !w_done && !w_load_last;
                    end
                end
                ST_B: if (b_fire) begin b_ready <= 1'b0; state <= ST_RESP; end
                ST_RESP: if (r_pop && !rsk_valid) begin req_ready <= 1'b1; state <= ST_IDLE; end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output assembly from registers and constant AXI fields.
    always_comb begin
        o_xmsto = '0;
        o_xmsto.ar_valid       = ar_valid;
        o_xmsto.ar_bits.addr   = a_addr;
        o_xmsto.ar_bits.len    = a_len;
        o_xmsto.ar_bits.size   = a_size;
        o_xmsto.ar_bits.burst  = AXI_BURST_INCR;
        o_xmsto.ar_id          = req_id;
        o_xmsto.ar_user        = req_user;
        o_xmsto.aw_valid       = aw_valid;
        o_xmsto.aw_bits.addr   = a_addr;
        o_xmsto.aw_bits.len    = a_len;
        o_xmsto.aw_bits.size   = a_size;
        o_xmsto.aw_bits.burst  = AXI_BURST_INCR;
        o_xmsto.aw_id          = req_id;
        o_xmsto.aw_user        = req_user;
        o_xmsto.w_valid        = w_valid;
        o_xmsto.w_data         = w_data;
        o_xmsto.w_strb         = w_strb;
        o_xmsto.w_last         = w_last;
        o_xmsto.b_ready        = b_ready;
        o_xmsto.r_ready        = r_ready;
    end

    assign o_req_ready   = req_ready;
    assign o_wdata_ready = wdata_ready;
    assign o_resp_valid  = resp_valid;
    assign o_resp_write  = resp_write;
    assign o_resp_rdata  = resp_rdata;
    assign o_resp_err    = resp_err;
    assign o_resp_last   = resp_last;
endmodule

// File: tb/tb_axi_mst_bridge.sv
// tb_axi_mst_bridge: directed vectors and hand-written sequences for axi_mst_bridge.
module tb_axi_mst_bridge;
    import axi_mst_pkg::*;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    axi4_master_in_type  xi;
    axi4_master_out_type xo;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [7:0]  req_len;
    logic        wdata_valid, wdata_ready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        resp_valid, resp_ready, resp_write, resp_err, resp_last;
    logic [63:0] resp_rdata;

    int total = 0;
    int bad = 0;

    axi_mst_bridge dut (
        .i_clk(clk), .i_nrst(nrst), .i_xmsti(xi), .o_xmsto(xo),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
        .i_req_addr(req_addr), .i_req_size(req_size), .i_req_len(req_len),
        .i_wdata_valid(wdata_valid), .o_wdata_ready(wdata_ready),
        .i_wdata(wdata), .i_wstrb(wstrb),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_write(resp_write),
        .o_resp_rdata(resp_rdata), .o_resp_err(resp_err), .o_resp_last(resp_last)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  resp;
        logic [63:0] data;
        logic        exp_err;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        xi = '0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0; req_len = '0;
        wdata_valid = 1'b0; wdata = '0; wstrb = '0; resp_ready = 1'b0;
    endtask

    function automatic logic [63:0] wpat(input int k);
        return 64'(k + 1) * 64'h1111_1111_1111_1111;
    endfunction

    // Present a request, then check the AXI address channel one cycle after the handshake.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len);
        int n;
        assert ((32'(addr[11:0]) + ((32'(len) + 32'd1) << size)) <= 32'd4096)
            else $error("request crosses a 4KB boundary");
        assert (len == 8'd0 || size <= 3'd3) else $error("burst size wider than data bus");
        n = 0;
        while (!req_ready && n < 20) begin tick(); n++; end
        chk("req_ready_before", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size; req_len = len;
        tick();
        req_valid = 1'b0;
        chk("req_ready_drop", 64'(req_ready), 64'd0);
        if (wr) begin
            chk("aw_fields", {xo.aw_valid, xo.aw_bits.addr, xo.aw_bits.len, xo.aw_bits.size, xo.aw_bits.burst},
                {1'b1, addr, len, size, 2'b01});
            chk("wdata_ready_pre_aw", 64'(wdata_ready), 64'd0);
        end else begin
            chk("ar_fields", {xo.ar_valid, xo.ar_bits.addr, xo.ar_bits.len, xo.ar_bits.size, xo.ar_bits.burst},
                {1'b1, addr, len, size, 2'b01});
        end
    endtask

    // mode 0: consumer always ready; 1: ready toggles 1,0,1,0; 2: ready low for 10 cycles.
    task automatic run_read(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                            input logic [1:0] resp, input logic [63:0] base, input logic exp_err, input int mode);
        int sent, got;
        logic r_hs, pop, first_seen, c_last, c_err, c_wr;
        logic [63:0] c_data;
        sent = 0; got = 0; first_seen = 1'b0;
        issue(1'b0, addr, size, len);
        xi.ar_ready = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (got > int'(len)) break;
            xi.r_valid = (sent <= int'(len));
            xi.r_data  = base + 64'(sent);
            xi.r_last  = (sent == int'(len));
            xi.r_resp  = resp;
            case (mode)
                1:       resp_ready = (cyc % 2 == 0);
                2:       resp_ready = (cyc >= 10);
                default: resp_ready = 1'b1;
            endcase
            r_hs = xi.r_valid && xo.r_ready;
            pop  = resp_valid && resp_ready;
            c_data = resp_rdata; c_last = resp_last; c_err = resp_err; c_wr = resp_write;
            tick();
            if (xo.ar_valid == 1'b0) xi.ar_ready = 1'b0;
            if (r_hs) sent++;
            if (pop) begin
                chk("rd_data", c_data, base + 64'(got));
                chk("rd_flags", {61'd0, c_last, c_err, c_wr}, {61'd0, got == int'(len), exp_err, 1'b0});
                got++;
            end
            if (mode == 2 && !first_seen && resp_valid) begin
                first_seen = 1'b1;
                chk("r_ready_backpressure", 64'(xo.r_ready), 64'd0);
            end
        end
        chk("rd_beats", 64'(got), 64'(len) + 64'd1);
        chk("rd_end_state", {62'd0, req_ready, resp_valid}, {62'd0, 1'b1, 1'b0});
        idle_inputs();
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                             input logic [1:0] bresp, input logic exp_err, input int aw_delay);
        int wsent, wgot;
        logic aw_done, early, b_given, got_resp;
        logic aw_hs, w_hs, wd_hs, b_hs, pop, c_wlast, c_last, c_err, c_wr;
        logic [63:0] c_wdata, c_rdata;
        logic [7:0]  c_strb;
        wsent = 0; wgot = 0; aw_done = 1'b0; early = 1'b0; b_given = 1'b0; got_resp = 1'b0;
        issue(1'b1, addr, size, len);
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (got_resp) break;
            xi.aw_ready = (cyc >= aw_delay) && !aw_done;
            wdata_valid = (wsent <= int'(len));
            wdata = wpat(wsent);
            wstrb = 8'hFF;
            xi.w_ready = 1'b1;
            xi.b_valid = (wgot > int'(len)) && !b_given;
            xi.b_resp = bresp;
            resp_ready = 1'b1;
            if (!aw_done && (wdata_ready || xo.w_valid)) early = 1'b1;
            aw_hs = xo.aw_valid && xi.aw_ready;
            w_hs  = xo.w_valid && xi.w_ready;
            wd_hs = wdata_valid && wdata_ready;
            b_hs  = xi.b_valid && xo.b_ready;
            pop   = resp_valid && resp_ready;
            c_wdata = xo.w_data; c_wlast = xo.w_last; c_strb = xo.w_strb;
            c_rdata = resp_rdata; c_last = resp_last; c_err = resp_err; c_wr = resp_write;
            tick();
            if (aw_hs) aw_done = 1'b1;
            if (wd_hs) wsent++;
            if (w_hs) begin
                chk("w_data", c_wdata, wpat(wgot));
                chk("w_last_strb", {55'd0, c_wlast, c_strb}, {55'd0, wgot == int'(len), 8'hFF});
                wgot++;
            end
            if (b_hs) b_given = 1'b1;
            if (pop) begin
                chk("wr_resp", {c_rdata, c_last, c_err, c_wr}, {64'd0, 1'b1, exp_err, 1'b1});
                got_resp = 1'b1;
            end
        end
        chk("w_before_aw", 64'(early), 64'd0);
        chk("wr_resp_seen", 64'(got_resp), 64'd1);
        chk("wr_beats", 64'(wgot), 64'(len) + 64'd1);
        chk("wr_end_ready", 64'(req_ready), 64'd1);
        idle_inputs();
    endtask

    initial begin
        tbl[0] = '{1'b0, 32'h0000_1000, 3'd3, 2'd0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
        tbl[1] = '{1'b0, 32'h0000_2008, 3'd3, 2'd2, 64'h0123_4567_89AB_CDEF, 1'b1};
        tbl[2] = '{1'b1, 32'h0000_3000, 3'd3, 2'd3, 64'h0,                   1'b1};
        tbl[3] = '{1'b1, 32'h0000_3010, 3'd2, 2'd0, 64'h0,                   1'b0};
        tbl[4] = '{1'b0, 32'h0000_4004, 3'd2, 2'd1, 64'h0000_0000_5555_AAAA, 1'b0};
        tbl[5] = '{1'b0, 32'h0000_0FF8, 3'd3, 2'd3, 64'hFFFF_0000_FFFF_0000, 1'b1};

        idle_inputs();
        nrst = 1'b0;
        repeat (3) tick();
        chk("reset_ctrl", {55'd0, req_ready, wdata_ready, resp_valid, xo.ar_valid, xo.aw_valid,
                           xo.w_valid, xo.w_last, xo.r_ready, xo.b_ready}, 64'd0);
        chk("reset_data", {xo.ar_bits.addr, resp_rdata[31:0]}, 64'd0);
        nrst = 1'b1;
        tick();
        chk("ready_after_reset", 64'(req_ready), 64'd1);

        // Single read with slave latency of 2 cycles after AR.
        issue(1'b0, 32'h0000_1000, 3'd3, 8'd0);
        xi.ar_ready = 1'b1;
        tick();
        xi.ar_ready = 1'b0;
        chk("ar_done", {62'd0, xo.ar_valid, xo.r_ready}, {62'd0, 1'b0, 1'b1});
        tick(); tick();
        xi.r_valid = 1'b1; xi.r_data = 64'hDEAD_BEEF_CAFE_F00D; xi.r_last = 1'b1; xi.r_resp = 2'd0;
        tick();
        xi.r_valid = 1'b0;
        chk("single_rdata", resp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
        chk("single_flags", {59'd0, resp_valid, resp_last, resp_err, resp_write, xo.r_ready},
            {59'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("single_done", {62'd0, resp_valid, req_ready}, {62'd0, 1'b0, 1'b1});

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].wr) run_write(tbl[i].addr, tbl[i].size, 8'd0, tbl[i].resp, tbl[i].exp_err, 1);
            else           run_read(tbl[i].addr, tbl[i].size, 8'd0, tbl[i].resp, tbl[i].data, tbl[i].exp_err, 0);
        end

        run_read(32'h0000_8000, 3'd3, 8'd3, 2'd0, 64'h1000_0000_0000_0A00, 1'b0, 1);
        run_read(32'h0000_9000, 3'd3, 8'd3, 2'd0, 64'h2000_0000_0000_0B00, 1'b0, 2);
        run_read(32'h0000_A000, 3'd3, 8'd7, 2'd0, 64'h3000_0000_0000_0C00, 1'b0, 0);
        run_write(32'h0000_B000, 3'd3, 8'd1, 2'd0, 1'b0, 3);
        run_write(32'h0000_C000, 3'd3, 8'd3, 2'd2, 1'b1, 0);

        // Reset in the middle of a write burst, after one W beat went out.
        issue(1'b1, 32'h0000_5000, 3'd3, 8'd3);
        xi.aw_ready = 1'b1;
        tick();
        xi.aw_ready = 1'b0;
        xi.w_ready = 1'b1; wdata_valid = 1'b1; wdata = 64'h5A5A_5A5A_5A5A_5A5A; wstrb = 8'hFF;
        tick(); tick();
        chk("mid_burst_w_valid", 64'(xo.w_valid), 64'd1);
        nrst = 1'b0;
        tick();
        chk("mid_reset_clear", {56'd0, req_ready, wdata_ready, resp_valid, xo.ar_valid, xo.aw_valid,
                                xo.w_valid, xo.r_ready, xo.b_ready}, 64'd0);
        idle_inputs();
        nrst = 1'b1;
        tick();
        chk("mid_reset_ready", 64'(req_ready), 64'd1);
        run_read(32'h0000_6000, 3'd3, 8'd0, 2'd0, 64'h7777_0000_8888_0000, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_mst_bridge.md
Name: axi_mst_bridge

Overview:
Bridges the codebase's simple request/response bus onto an AXI4 master port, so internal engines (DMA, GPU fetch units) can act as initiators on the system interconnect. It is the initiator-side counterpart of the AXI slave adapter. It accepts one request (read or write, single beat or INCR burst), drives the AR/R or AW/W/B channels, and returns read beats or a single write completion. One transaction is outstanding at a time.

Parameters:
- req_id, 0: constant value driven on ar_id and aw_id.
- req_user, 0: constant value driven on ar_user and aw_user.

Ports:
- i_clk  in  1  clock.
- i_nrst  in  1  reset, active LOW.
- i_xmsti  in  axi4_master_in_type  AXI master input (ready signals, R and B channels).
- o_xmsto  out  axi4_master_out_type  AXI master output (AR/AW/W channels, r_ready, b_ready).
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request accepted when valid and ready are both high.
- i_req_write  in  1  1 = write, 0 = read.
- i_req_addr  in  CFG_SYSBUS_ADDR_BITS  byte address.
- i_req_size  in  3  AXI size code (bytes = 1<<size).
- i_req_len  in  8  number of beats minus 1 (AXI len).
- i_wdata_valid  in  1  write beat valid.
- o_wdata_ready  out  1  write beat accepted.
- i_wdata  in  CFG_SYSBUS_DATA_BITS  write data.
- i_wstrb  in  CFG_SYSBUS_DATA_BYTES  write strobes.
- o_resp_valid  out  1  response valid.
- i_resp_ready  in  1  response consumer ready.
- o_resp_write  out  1  response belongs to a write (B) transaction.
- o_resp_rdata  out  CFG_SYSBUS_DATA_BITS  read data (0 for writes).
- o_resp_err  out  1  resp[1] of the R or B beat (SLVERR/DECERR).
- o_resp_last  out  1  last beat (always 1 for writes).

Behaviour:
- Clocking and reset: single clock i_clk; reset synchronous, active-low on i_nrst.
- Reset values: all of the following are 0:
  - o_req_ready, o_wdata_ready, o_resp_* outputs;
  - ar_valid, aw_valid, w_valid, w_last, r_ready, b_ready;
  - address and data fields.
  - State goes to idle. Reset mid-transaction abandons the transfer without draining AXI.
- All outputs are registered.
- Fixed AXI fields: burst = INCR; lock/cache/prot/qos/region = 0; id = req_id; user = req_user.
- States:
  - idle: o_req_ready=1. On i_req_valid&o_req_ready, latch addr/size/len/write and drop o_req_ready.
    - Read: ar_valid=1, go to ar.
    - Write: aw_valid=1, go to aw.
  - ar: hold AR fields stable. When ar_ready&ar_valid: ar_valid=0, r_ready=~o_resp_valid|i_resp_ready, go to r.
  - r: each R handshake loads o_resp_rdata/err/last, o_resp_valid=1, o_resp_write=0.
    - r_ready = ~o_resp_valid_next | i_resp_ready, so a full output register is never overwritten.
    - On the handshake of the R beat with r_last=1, go to resp_wait.
    - Beat count is not checked; r_last alone terminates the transfer.
  - aw: when aw_ready: aw_valid=0, go to w. Beat counter = latched len.
  - w: single-entry W register.
    - o_wdata_ready = ~w_valid | w_ready.
    - On i_wdata_valid&o_wdata_ready: load data/strb, w_valid=1, w_last=(counter==0), decrement counter.
    - On handshake of the beat with w_last: w_valid=0, o_wdata_ready=0, b_ready=1, go to b.
    - o_wdata_ready=0 once the last beat has been loaded.
  - b: on b_valid&b_ready: b_ready=0, o_resp_valid=1, o_resp_write=1, o_resp_last=1, o_resp_err=b_resp[1], go to resp_wait.
  - resp_wait: when o_resp_valid&i_resp_ready: o_resp_valid=0, o_req_ready=1, go to idle.
- Response clearing: o_resp_valid clears on i_resp_ready unless a new R beat loads in the same cycle; load has priority.
- Simultaneous events: i_wdata_valid asserted before the AW handshake is ignored, because wdata_ready=0 outside w.
- Back-to-back: a new request is accepted at the earliest 1 cycle after the final response handshake.
- 4KB crossing and len>0 with size > data width are caller errors. They are not split or checked; the bench asserts against them.
- Throughput: one beat per cycle sustained in both directions when the far side is always ready.

Test Plan:
- Single read: addr=0x1000, size=3, len=0; slave returns data 0xDEADBEEF_CAFEF00D, RESP=OKAY after 2 cycles.
  - Required: AR seen 1 cycle after the request handshake; one response with last=1, err=0, that data; o_req_ready high again 1 cycle after the response handshake.
- Read burst: len=3, r_ready from consumer toggling 1,0,1,0.
  - Required: 4 responses in order, last only on the 4th; no beat lost or duplicated; araddr=base, arlen=3.
- Write burst: len=1, two beats 0x11../0x22.. with strb 0xFF, slave aw_ready delayed 3 cycles, w_ready=1.
  - Required: W beats only after the AW handshake; wlast on the 2nd beat; one response with write=1, last=1.
- Error: read with RESP=SLVERR(2), then write with BRESP=DECERR(3).
  - Required: o_resp_err=1 on both.
- Backpressure: i_resp_ready=0 for 10 cycles during a 4-beat read.
  - Required: r_ready drops after the 1st beat is captured; all 4 beats delivered correctly after release.
- Reset mid-burst: assert i_nrst=0 in state w after 1 beat.
  - Required: next cycle all valids 0, o_req_ready=0, then 1 one cycle after release.
